// File: rtl/d5m_pattern_source_if.sv
// Pixel-side bundle between the synthetic D5M source and its consumer.
// The source uses the master modport; the capture path or a bench uses the slave modport.
interface d5m_pattern_source_if #(
  parameter int unsigned DATA_W = 12
);
  logic              iSTART;
  logic              iSTOP;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] oDATA;
  logic              oFVAL;
  logic              oLVAL;
  logic              oBUSY;
  logic [15:0]       oFRAME_CNT;

  modport master (
    input  iSTART, iSTOP, iMODE,
    output oDATA, oFVAL, oLVAL, oBUSY, oFRAME_CNT
  );

  modport slave (
    output iSTART, iSTOP, iMODE,
    input  oDATA, oFVAL, oLVAL, oBUSY, oFRAME_CNT
  );
endinterface

// File: rtl/d5m_pattern_source.sv
// Synthetic D5M sensor: FVAL/LVAL framing with selectable Bayer test patterns.
// Define D5M_PATTERN_SOURCE_LFSR_EN to replace the mode-3 constant with a per-frame LFSR.
module d5m_pattern_source #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 960,
  parameter int unsigned H_BLANK  = 16,
  parameter int unsigned V_BLANK  = 32,
  parameter int unsigned FV_LEAD  = 4,
  parameter int unsigned FV_TRAIL = 4,
  parameter int unsigned DATA_W   = 12
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  d5m_pattern_source_if.master  bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VB_LAST    = CNT_W'(V_BLANK - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(FV_LEAD - 1);
  localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(FV_TRAIL - 1);

`ifndef SYNTHESIS
  if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_params
    $error("d5m_pattern_source: H_ACTIVE and V_ACTIVE must be non-zero");
  end
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_ACTIVE, S_HBLANK, S_TRAIL, S_VBLANK
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic [1:0]         mode_q;
  logic               stop_pending;

  logic [CNT_W-1:0]   x_inc_c;
  logic [CNT_W-1:0]   y_inc_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               stop_nxt_c;
  logic [DATA_W-1:0]  mode3_c;

  assign x_inc_c    = x + CNT_W'(1);
  assign y_inc_c    = y + CNT_W'(1);
  assign cnt_inc_c  = cnt + CNT_W'(1);
  // iSTOP wins over iSTART when both are seen while running
  assign stop_nxt_c = bus.iSTOP | (stop_pending & ~bus.iSTART);

`ifdef D5M_PATTERN_SOURCE_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr;
  logic [15:0] lfsr_step_c;
  // Fibonacci, taps 16,14,13,11, shifting toward bit 0
  assign lfsr_step_c = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign mode3_c     = DATA_W'(lfsr_step_c);
`else
  assign mode3_c     = DATA_W'(12'h101);
`endif

  // Pixel value for Bayer site (x, y); y is passed as the two bits the patterns use
  function automatic logic [DATA_W-1:0] pix(
    input logic [1:0]        mode,
    input logic [CNT_W-1:0]  px,
    input logic              py0,
    input logic              py3,
    input logic [DATA_W-1:0] m3
  );
    logic [DATA_W-1:0] v;
    v = '0;
    case (mode)
      2'd0: begin
        case ({py0, px[0]})
          2'b01:   v = DATA_W'(12'hFFF);
          2'b10:   v = DATA_W'(12'h000);
          default: v = DATA_W'(12'h800);
        endcase
      end
      2'd1:    v = DATA_W'(px);
      2'd2:    v = (px[3] ^ py3) ? DATA_W'(12'hFFF) : DATA_W'(12'h000);
      default: v = m3;
    endcase
    return v;
  endfunction

  // Frame sequencer; every output is set on the edge that enters the cycle it describes
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state          <= S_IDLE;
      cnt            <= '0;
      x              <= '0;
      y              <= '0;
      mode_q         <= '0;
      stop_pending   <= 1'b0;
      bus.oDATA      <= '0;
      bus.oFVAL      <= 1'b0;
      bus.oLVAL      <= 1'b0;
      bus.oBUSY      <= 1'b0;
      bus.oFRAME_CNT <= '0;
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
      lfsr           <= LFSR_SEED;
`endif
    end else begin
      if (state != S_IDLE) stop_pending <= stop_nxt_c;
      case (state)
        S_IDLE: begin
          if (bus.iSTART && !bus.iSTOP) begin
            state        <= S_LEAD;
            cnt          <= '0;
            x            <= '0;
            y            <= '0;
            mode_q       <= bus.iMODE;
            stop_pending <= 1'b0;
            bus.oFVAL    <= 1'b1;
            bus.oBUSY    <= 1'b1;
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
            lfsr         <= LFSR_SEED;
`endif
          end
        end
        S_LEAD: begin
          if (cnt == LEAD_LAST) begin
            state     <= S_ACTIVE;
            x         <= '0;
            bus.oLVAL <= 1'b1;
            bus.oDATA <= pix(mode_q, '0, y[0], y[3], mode3_c);
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
            lfsr      <= lfsr_step_c;
`endif
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        S_ACTIVE: begin
          if (x == X_LAST) begin
            state     <= (y < Y_LAST) ? S_HBLANK : S_TRAIL;
            cnt       <= '0;
            bus.oLVAL <= 1'b0;
            bus.oDATA <= '0;
          end else begin
            x         <= x_inc_c;
            bus.oDATA <= pix(mode_q, x_inc_c, y[0], y[3], mode3_c);
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
            lfsr      <= lfsr_step_c;
`endif
          end
        end
        S_HBLANK: begin
          if (cnt == HB_LAST) begin
            state     <= S_ACTIVE;
            x         <= '0;
            y         <= y_inc_c;
            bus.oLVAL <= 1'b1;
            bus.oDATA <= pix(mode_q, '0, y_inc_c[0], y_inc_c[3], mode3_c);
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
            lfsr      <= lfsr_step_c;
`endif
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        S_TRAIL: begin
          if (cnt == TRAIL_LAST) begin
            state          <= S_VBLANK;
            cnt            <= '0;
            bus.oFVAL      <= 1'b0;
            bus.oFRAME_CNT <= bus.oFRAME_CNT + 16'd1;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        S_VBLANK: begin
          if (cnt == VB_LAST) begin
            cnt <= '0;
            x   <= '0;
            y   <= '0;
            if (stop_nxt_c) begin
              state        <= S_IDLE;
              stop_pending <= 1'b0;
              bus.oBUSY    <= 1'b0;
            end else begin
              state     <= S_LEAD;
              mode_q    <= bus.iMODE;
              bus.oFVAL <= 1'b1;
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
              lfsr      <= LFSR_SEED;
`endif
            end
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus.oFVAL <= 1'b0;
          bus.oLVAL <= 1'b0;
          bus.oDATA <= '0;
          bus.oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d5m_pattern_source.sv
// Scoreboard bench for d5m_pattern_source with a 4x2 active window.
// Expected FVAL/LVAL/DATA samples are queued per frame and compared every cycle.
module tb_d5m_pattern_source;

  localparam int unsigned HA = 4;
  localparam int unsigned VA = 2;
  localparam int unsigned HB = 2;
  localparam int unsigned VB = 3;
  localparam int unsigned FL = 1;
  localparam int unsigned FT = 1;
  localparam int unsigned DW = 12;

  typedef struct packed {
    logic          fval;
    logic          lval;
    logic [DW-1:0] data;
  } smp_t;

  logic clk;
  logic rst_n;
  smp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  d5m_pattern_source_if #(.DATA_W(DW)) bus ();

  d5m_pattern_source #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
    .FV_LEAD(FL), .FV_TRAIL(FT), .DATA_W(DW)
  ) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Queue the 15 samples of one frame for the given latched mode
  task automatic push_frame(input logic [1:0] mode);
    logic [DW-1:0] d;
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
    logic [15:0] l;
    l = 16'hACE1;
`endif
    for (int i = 0; i < int'(FL); i++) exp_q.push_back({1'b1, 1'b0, 12'h000});
    for (int y = 0; y < int'(VA); y++) begin
      for (int x = 0; x < int'(HA); x++) begin
        case (mode)
          2'd0: begin
            if (y % 2 == 0) d = (x % 2 == 0) ? 12'h800 : 12'hFFF;
            else            d = (x % 2 == 0) ? 12'h000 : 12'h800;
          end
          2'd1: d = DW'(x);
          2'd2: d = (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
          default: begin
`ifdef D5M_PATTERN_SOURCE_LFSR_EN
            l = {l[5] ^ l[3] ^ l[2] ^ l[0], l[15:1]};
            d = l[DW-1:0];
`else
            d = 12'h101;
`endif
          end
        endcase
        exp_q.push_back({1'b1, 1'b1, d});
      end
      if (y < int'(VA) - 1)
        for (int i = 0; i < int'(HB); i++) exp_q.push_back({1'b1, 1'b0, 12'h000});
    end
    for (int i = 0; i < int'(FT); i++) exp_q.push_back({1'b1, 1'b0, 12'h000});
    for (int i = 0; i < int'(VB); i++) exp_q.push_back({1'b0, 1'b0, 12'h000});
  endtask

  // Compare n consecutive cycles against the scoreboard, starting at the current negedge
  task automatic check_samples(input int n, input string name);
    smp_t got;
    smp_t e;
    for (int i = 0; i < n; i++) begin
      got = {bus.oFVAL, bus.oLVAL, bus.oDATA};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s[%0d]: no expected sample queued, got %b/%b/%h", name, i,
                 got.fval, got.lval, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL %s[%0d]: fval/lval/data got %b/%b/%h expected %b/%b/%h", name, i,
                   got.fval, got.lval, got.data, e.fval, e.lval, e.data);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    bus.iSTART = 1'b0;
    bus.iSTOP  = 1'b0;
    bus.iMODE  = 2'd0;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge where the LEAD cycle is visible
  task automatic start_pulse(input logic [1:0] mode);
    bus.iMODE  = mode;
    bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.oBUSY !== 1'b0 || bus.oFVAL !== 1'b0 || bus.oLVAL !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy/fval/lval got %b/%b/%b expected 0/0/0", name,
               bus.oBUSY, bus.oFVAL, bus.oLVAL);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp_cnt);
    checks++;
    if (bus.oFRAME_CNT !== exp_cnt) begin
      errors++;
      $display("FAIL %s: frame_cnt got %0d expected %0d", name, bus.oFRAME_CNT, exp_cnt);
    end
  endtask

  task automatic test_reset();
    bus.iSTART = 1'b0;
    bus.iSTOP  = 1'b0;
    bus.iMODE  = 2'd0;
    rst_n      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.oFVAL, bus.oLVAL, bus.oBUSY, bus.oDATA, bus.oFRAME_CNT} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: fval/lval/busy/data/cnt got %b/%b/%b/%h/%h expected all 0",
               bus.oFVAL, bus.oLVAL, bus.oBUSY, bus.oDATA, bus.oFRAME_CNT);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle("reset_idle");
    end
  endtask

  task automatic test_basic_ramp();
    do_reset();
    push_frame(2'd1);
    start_pulse(2'd1);
    check_samples(11, "ramp");
    check_cnt("ramp_cnt_before_fall", 16'd0);
    check_samples(1, "ramp");
    check_cnt("ramp_cnt_at_fall", 16'd1);
    check_samples(3, "ramp");
    checks++;
    if (bus.oFVAL !== 1'b1 || bus.oBUSY !== 1'b1) begin
      errors++;
      $display("FAIL ramp_next_lead: fval/busy got %b/%b expected 1/1", bus.oFVAL, bus.oBUSY);
    end
  endtask

  task automatic test_flat();
    do_reset();
    push_frame(2'd0);
    start_pulse(2'd0);
    check_samples(15, "flat");
  endtask

  task automatic test_stop_restart();
    do_reset();
    repeat (3) push_frame(2'd1);
    start_pulse(2'd1);
    check_samples(30, "stop_f12");
    check_cnt("stop_cnt_f2", 16'd2);
    check_samples(8, "stop_f3");
    bus.iSTOP = 1'b1;
    check_samples(1, "stop_f3");
    bus.iSTOP = 1'b0;
    check_samples(6, "stop_f3");
    check_idle("stop_idle");
    check_cnt("stop_cnt_f3", 16'd3);
    bus.iSTART = 1'b1;
    bus.iSTOP  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle("start_and_stop_idle");
    end
    bus.iSTART = 1'b0;
    bus.iSTOP  = 1'b0;
    check_cnt("stop_cnt_hold", 16'd3);
  endtask

  task automatic test_mode_latch();
    do_reset();
    push_frame(2'd0);
    push_frame(2'd2);
    start_pulse(2'd0);
    check_samples(3, "latch_f1");
    bus.iMODE = 2'd2;
    check_samples(12, "latch_f1");
    check_samples(15, "latch_f2");
  endtask

  task automatic test_async_reset();
    do_reset();
    push_frame(2'd1);
    push_frame(2'd1);
    start_pulse(2'd1);
    check_samples(18, "arst_run");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oFVAL, bus.oLVAL, bus.oDATA, bus.oFRAME_CNT, bus.oBUSY} !== '0) begin
      errors++;
      $display("FAIL arst_immediate: fval/lval/data/cnt/busy got %b/%b/%h/%h/%b expected all 0",
               bus.oFVAL, bus.oLVAL, bus.oDATA, bus.oFRAME_CNT, bus.oBUSY);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_idle("arst_stay_idle");
    end
  endtask

  task automatic test_mode3();
    do_reset();
    push_frame(2'd3);
    push_frame(2'd3);
    start_pulse(2'd3);
    check_samples(30, "mode3");
  endtask

  initial begin
    test_reset();
    test_basic_ramp();
    test_flat();
    test_stop_restart();
    test_mode_latch();
    test_async_reset();
    test_mode3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
